// File: rtl/stream_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | stream_arbiter: packet-level round-robin mux of N byte streams onto one |
// | registered AXI-Stream output, with optional source-ID header byte.      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module stream_arbiter #(
  parameter int         N_SRC       = 3,
  parameter bit         HEADER_EN   = 1'b1,
  parameter logic [7:0] HEADER_BASE = 8'hA0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_SRC*8-1:0] i_tdata,
  input  logic [N_SRC-1:0]   i_tlast,
  input  logic [N_SRC-1:0]   i_tvalid,
  output logic [N_SRC-1:0]   o_tready,
  output logic [7:0]         o_tdata,
  output logic               o_tlast,
  output logic               o_tvalid,
  input  logic               i_tready,
  output logic [N_SRC-1:0]   o_grant,
  output logic               o_busy
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_PASS   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [N_SRC-1:0]   grant_q, grant_d;
  logic [7:0]         tdata_q, tdata_d;
  logic               tlast_q, tlast_d;
  logic               tvalid_q, tvalid_d;

  logic               slot_free;
  logic               req_found;
  logic [IDX_W-1:0]   req_idx;
  logic [7:0]         src_data;
  logic               src_last;
  logic               src_valid;

  assign slot_free = !tvalid_q || i_tready;
  assign src_data  = i_tdata[int'(gidx_q)*8 +: 8];
  assign src_last  = i_tlast[gidx_q];
  assign src_valid = i_tvalid[gidx_q];

  // Descending scan so the requester closest to rr (smallest offset) wins.
  always_comb begin
    req_found = 1'b0;
    req_idx   = rr_q;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (i_tvalid[(int'(rr_q) + i) % N_SRC]) begin
        req_found = 1'b1;
        req_idx   = IDX_W'((int'(rr_q) + i) % N_SRC);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    gidx_d   = gidx_q;
    grant_d  = grant_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q && !i_tready;
    o_tready = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_found) begin
          gidx_d          = req_idx;
          grant_d         = '0;
          grant_d[req_idx] = 1'b1;
          state_d         = HEADER_EN ? ST_HEADER : ST_PASS;
        end
      end
      ST_HEADER: begin
        if (slot_free) begin
          tdata_d  = HEADER_BASE + 8'(gidx_q);
          tlast_d  = 1'b0;
          tvalid_d = 1'b1;
          state_d  = ST_PASS;
        end
      end
      ST_PASS: begin
        if (slot_free) begin
          o_tready = grant_q;
        end
        if (slot_free && src_valid) begin
          tdata_d  = src_data;
          tlast_d  = src_last;
          tvalid_d = 1'b1;
          if (src_last) begin
            state_d = ST_IDLE;
            grant_d = '0;
            rr_d    = (gidx_q == IDX_W'(N_SRC - 1)) ? '0 : gidx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      rr_q     <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign o_tdata  = tdata_q;
  assign o_tlast  = tlast_q;
  assign o_tvalid = tvalid_q;
  assign o_grant  = grant_q;
  assign o_busy   = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_stream_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_stream_arbiter: directed scoreboard bench for stream_arbiter, with   |
// | and without header bytes.                     Revision: 1.0            |
// +------------------------------------------------------------------------+
module tb_stream_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] tdata;
  logic [2:0]  tlast, tvalid;
  logic        i_tready;

  logic [2:0]  tready_a, grant_a, tready_b, grant_b;
  logic [7:0]  tdata_a, tdata_b;
  logic        tlast_a, tvalid_a, busy_a, tlast_b, tvalid_b, busy_b;

  logic        sel_b;
  logic [2:0]  tready_sel, grant_sel;
  logic [7:0]  tdata_sel;
  logic        tlast_sel, tvalid_sel, busy_sel;

  logic [8:0]  src_q [3][$];
  logic [8:0]  exp_q [$];
  logic [2:0]  stall;
  bit          mon_en;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  stream_arbiter #(.N_SRC(3), .HEADER_EN(1'b1), .HEADER_BASE(8'hA0)) u_dut_hdr (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata), .i_tlast(tlast), .i_tvalid(tvalid),
    .o_tready(tready_a), .o_tdata(tdata_a), .o_tlast(tlast_a), .o_tvalid(tvalid_a),
    .i_tready(i_tready), .o_grant(grant_a), .o_busy(busy_a)
  );

  stream_arbiter #(.N_SRC(3), .HEADER_EN(1'b0), .HEADER_BASE(8'hA0)) u_dut_nohdr (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata), .i_tlast(tlast), .i_tvalid(tvalid),
    .o_tready(tready_b), .o_tdata(tdata_b), .o_tlast(tlast_b), .o_tvalid(tvalid_b),
    .i_tready(i_tready), .o_grant(grant_b), .o_busy(busy_b)
  );

  always_comb begin
    tready_sel = sel_b ? tready_b : tready_a;
    grant_sel  = sel_b ? grant_b  : grant_a;
    tdata_sel  = sel_b ? tdata_b  : tdata_a;
    tlast_sel  = sel_b ? tlast_b  : tlast_a;
    tvalid_sel = sel_b ? tvalid_b : tvalid_a;
    busy_sel   = sel_b ? busy_b   : busy_a;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source models: each queue entry is {tlast, data}; held until accepted.
  initial begin : p_sources
    logic [2:0] acc;
    bit         rst_seen;
    tvalid = '0;
    tdata  = '0;
    tlast  = '0;
    forever begin
      @(negedge clk);
      rst_seen = !rst_n;
      acc      = tvalid & tready_sel;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (rst_seen)    src_q[k].delete();
        else if (acc[k]) void'(src_q[k].pop_front());
        if (src_q[k].size() > 0 && !stall[k]) begin
          tvalid[k]         = 1'b1;
          tdata[k*8 +: 8]   = src_q[k][0][7:0];
          tlast[k]          = src_q[k][0][8];
        end else begin
          tvalid[k]         = 1'b0;
          tdata[k*8 +: 8]   = 8'h00;
          tlast[k]          = 1'b0;
        end
      end
    end
  end

  initial begin : p_monitor
    bit         hold = 1'b0;
    logic [8:0] hold_val = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        hold = 1'b0;
        continue;
      end
      if (hold) begin
        check("hold_valid", 32'(tvalid_sel), 32'd1);
        check("hold_data", 32'({tlast_sel, tdata_sel}), 32'(hold_val));
      end
      check("tready_outside_grant", 32'(tready_sel & ~grant_sel), 32'd0);
      if (tvalid_sel && !i_tready)
        check("tready_under_backpressure", 32'(tready_sel), 32'd0);
      if (tvalid_sel && i_tready) begin
        if (exp_q.size() == 0)
          check("unexpected_beat", 32'({tlast_sel, tdata_sel}), 32'hFFFF_FFFF);
        else
          check("beat", 32'({tlast_sel, tdata_sel}), 32'(exp_q.pop_front()));
      end
      hold     = tvalid_sel && !i_tready;
      hold_val = {tlast_sel, tdata_sel};
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && src_q[0].size() == 0 && src_q[1].size() == 0 &&
          src_q[2].size() == 0 && !busy_sel && !tvalid_sel) return;
    end
    check({name, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_grant(input logic [2:0] g, input string name);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (grant_sel == g) return;
    end
    check({name, "_grant_timeout"}, 32'(grant_sel), 32'(g));
  endtask

  task automatic wait_src_left(input int k, input int n, input string name);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (src_q[k].size() <= n) return;
    end
    check({name, "_src_timeout"}, 32'(src_q[k].size()), 32'(n));
  endtask

  task automatic push_src(input int k, input logic [8:0] v);
    src_q[k].push_back(v);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_tvalid"}, 32'(tvalid_sel), 32'd0);
    check({name, "_tlast"},  32'(tlast_sel),  32'd0);
    check({name, "_tdata"},  32'(tdata_sel),  32'd0);
    check({name, "_grant"},  32'(grant_sel),  32'd0);
    check({name, "_busy"},   32'(busy_sel),   32'd0);
    check({name, "_tready"}, 32'(tready_sel), 32'd0);
  endtask

  initial begin : p_watchdog
    #500000;
    check("watchdog", 32'd0, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : p_main
    rst_n    = 1'b0;
    i_tready = 1'b1;
    stall    = '0;
    sel_b    = 1'b0;
    mon_en   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;

    // Single packet from source 1 with latency checks
    @(negedge clk);
    push_src(1, 9'h011); push_src(1, 9'h022); push_src(1, 9'h133);
    exp_q = {9'h0A1, 9'h011, 9'h022, 9'h133};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("single_grant", 32'(grant_sel), 32'b010);
    check("single_busy", 32'(busy_sel), 32'd1);
    check("single_no_early_valid", 32'(tvalid_sel), 32'd0);
    @(negedge clk);
    check("single_header", 32'({tvalid_sel, tdata_sel}), 32'h1A1);
    check("single_tready", 32'(tready_sel), 32'b010);
    @(negedge clk);
    check("single_first_payload", 32'(tdata_sel), 32'h11);
    wait_idle("single");

    // rr now 2: contention between sources 0 and 2 serves 2 first
    @(negedge clk);
    push_src(0, 9'h101); push_src(2, 9'h102);
    exp_q = {9'h0A2, 9'h102, 9'h0A0, 9'h101};
    wait_idle("rr_after_single");

    // Fairness after reset
    do_reset();
    @(negedge clk);
    push_src(0, 9'h001); push_src(0, 9'h102); push_src(0, 9'h003); push_src(0, 9'h104);
    push_src(1, 9'h011); push_src(1, 9'h112); push_src(1, 9'h013); push_src(1, 9'h114);
    push_src(2, 9'h021); push_src(2, 9'h122); push_src(2, 9'h023); push_src(2, 9'h124);
    exp_q = {9'h0A0, 9'h001, 9'h102, 9'h0A1, 9'h011, 9'h112, 9'h0A2, 9'h021, 9'h122,
             9'h0A0, 9'h003, 9'h104, 9'h0A1, 9'h013, 9'h114, 9'h0A2, 9'h023, 9'h124};
    wait_idle("fairness");

    // Backpressure on source 0's 4-byte packet
    @(negedge clk);
    push_src(0, 9'h031); push_src(0, 9'h032); push_src(0, 9'h033); push_src(0, 9'h134);
    exp_q = {9'h0A0, 9'h031, 9'h032, 9'h033, 9'h134};
    for (int c = 0; c < 24; c++) begin
      @(posedge clk);
      #1 i_tready = ~i_tready;
    end
    @(posedge clk);
    #1 i_tready = 1'b1;
    wait_idle("backpressure");

    // Source 2 stalls mid-packet while source 0 requests
    @(negedge clk);
    push_src(2, 9'h041); push_src(2, 9'h042); push_src(2, 9'h043); push_src(2, 9'h144);
    exp_q = {9'h0A2, 9'h041, 9'h042, 9'h043, 9'h144, 9'h0A0, 9'h151};
    wait_grant(3'b100, "stall");
    push_src(0, 9'h151);
    wait_src_left(2, 3, "stall");
    stall[2] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_grant_held", 32'(grant_sel), 32'b100);
    end
    stall[2] = 1'b0;
    wait_idle("stall");

    // Reset in the middle of source 1's payload
    mon_en = 1'b0;
    @(negedge clk);
    push_src(1, 9'h061); push_src(1, 9'h062); push_src(1, 9'h063); push_src(1, 9'h164);
    wait_src_left(1, 2, "midreset");
    do_reset();
    @(negedge clk);
    check_all_zero("midreset");
    mon_en = 1'b1;
    push_src(1, 9'h171); push_src(2, 9'h181);
    exp_q = {9'h0A1, 9'h171, 9'h0A2, 9'h181};
    wait_idle("after_reset");

    // No-header instance: back-to-back single-byte packets
    sel_b = 1'b1;
    do_reset();
    @(negedge clk);
    push_src(0, 9'h15A); push_src(0, 9'h15B);
    exp_q = {9'h15A, 9'h15B};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("nohdr_first", 32'({tvalid_sel, tlast_sel, tdata_sel}), 32'h35A);
    @(negedge clk);
    check("nohdr_gap", 32'(tvalid_sel), 32'd0);
    @(negedge clk);
    check("nohdr_second", 32'({tvalid_sel, tlast_sel, tdata_sel}), 32'h35B);
    wait_idle("nohdr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
